// File: rtl/serial_add64_pkg.sv
// Shared definitions for the serial multi-precision adder: chunk width,
// FSM state encoding and the chunk-index width helper.
package serial_add64_pkg;

   localparam int CHUNK = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // A single-chunk operand still needs a one-bit index register.
   function automatic int idx_width(input int words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/add16_slice.sv
// Combinational 16-bit carry-lookahead adder: four 4-bit groups whose
// group carries are formed directly from group generate/propagate terms.
module add16_slice
   import serial_add64_pkg::*;
(
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             c_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             c_o
);

   logic [CHUNK-1:0] g;
   logic [CHUNK-1:0] p;
   logic [CHUNK-1:0] c;
   logic [3:0]       grp_g;
   logic [3:0]       grp_p;
   logic [4:0]       grp_c;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_group
         assign grp_g[gi] = g[4*gi+3]
                          | (p[4*gi+3] & g[4*gi+2])
                          | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                          | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
         assign grp_p[gi] = &p[4*gi +: 4];

         // Bit carries inside the group are expanded from the group carry-in.
         assign c[4*gi]   = grp_c[gi];
         assign c[4*gi+1] = g[4*gi] | (p[4*gi] & grp_c[gi]);
         assign c[4*gi+2] = g[4*gi+1]
                          | (p[4*gi+1] & g[4*gi])
                          | (p[4*gi+1] & p[4*gi] & grp_c[gi]);
         assign c[4*gi+3] = g[4*gi+2]
                          | (p[4*gi+2] & g[4*gi+1])
                          | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                          | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & grp_c[gi]);
      end
   endgenerate

   assign grp_c[0] = c_i;
   assign grp_c[1] = grp_g[0] | (grp_p[0] & c_i);
   assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c_i);
   assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[2] & grp_p[1] & grp_p[0] & c_i);
   assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c_i);

   assign sum_o = p ^ c;
   assign c_o   = grp_c[4];

endmodule

// File: rtl/serial_add64.sv
// Wide adder/subtractor that streams operands one 16-bit chunk per cycle
// through a single lookahead slice, holding the carry between chunks.
module serial_add64
   import serial_add64_pkg::*;
#(
   parameter  int WORDS = 4,
   localparam int W     = CHUNK * WORDS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         c_out,
   output logic         overflow
);

   localparam int IW = idx_width(WORDS);

   state_e          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    sum_q;
   logic            carry_q;
   logic            ovf_q;
   logic [IW-1:0]   idx_q;

   logic [CHUNK-1:0] a_words [WORDS];
   logic [CHUNK-1:0] b_words [WORDS];
   logic [CHUNK-1:0] slice_sum_d;
   logic             slice_carry_d;
   logic             last_chunk;

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_chunk
         assign a_words[gi] = a_q[gi*CHUNK +: CHUNK];
         assign b_words[gi] = b_q[gi*CHUNK +: CHUNK];
      end
   endgenerate

   add16_slice u_slice (
      .a_i   (a_words[idx_q]),
      .b_i   (b_words[idx_q]),
      .c_i   (carry_q),
      .sum_o (slice_sum_d),
      .c_o   (slice_carry_d)
   );

   assign last_chunk = (idx_q == IW'(WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1, so b is inverted once at capture.
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : c_in;
                  sum_q   <= '0;
                  ovf_q   <= 1'b0;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < WORDS; i++) begin
                  if (idx_q == IW'(i)) sum_q[i*CHUNK +: CHUNK] <= slice_sum_d;
               end
               carry_q <= slice_carry_d;
               if (last_chunk) begin
                  // Top result bit is still in flight, so take it from the slice.
                  ovf_q   <= (a_q[W-1] == b_q[W-1]) & (slice_sum_d[CHUNK-1] != a_q[W-1]);
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign c_out     = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add64.sv
// Scoreboard bench for serial_add64 (WORDS = 4): expected results are queued
// at operand accept and compared when the DUT presents its result.
module tb_serial_add64;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         overflow;

   typedef struct {
      logic [W-1:0] sum;
      logic         c_out;
      logic         ovf;
   } result_t;

   result_t exp_q [$];
   int n_checks = 0;
   int n_pass   = 0;

   serial_add64 #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, expv);
   endtask

   function automatic result_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                     input logic ci, input logic sb);
      result_t r;
      logic [W:0]   full;
      logic [W-1:0] bb;
      bb     = sb ? ~bv : bv;
      full   = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
      r.sum  = full[W-1:0];
      r.c_out = full[W];
      r.ovf  = (av[W-1] == bb[W-1]) && (r.sum[W-1] != av[W-1]);
      return r;
   endfunction

   // hold: DONE cycles with out_ready low while a different operand pair is offered.
   task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic sb, input int hold);
      result_t e;
      int      lat;
      int      guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check_val({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
      exp_q.push_back(model(av, bv, ci, sb));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_val({name, "_busy"}, {63'd0, in_ready}, 64'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val({name, "_latency"}, 64'(lat), 64'(WORDS));
      if (exp_q.size() == 0) begin
         check_val({name, "_scoreboard"}, 64'd0, 64'd1);
         return;
      end
      e = exp_q.pop_front();
      check_val({name, "_sum"}, sum, e.sum);
      check_val({name, "_c_out"}, {63'd0, c_out}, {63'd0, e.c_out});
      check_val({name, "_ovf"}, {63'd0, overflow}, {63'd0, e.ovf});
      $display("op %s: a=%h b=%h c_in=%0d sub=%0d -> sum=%h c_out=%0d ovf=%0d lat=%0d",
               name, av, bv, ci, sb, sum, c_out, overflow, lat);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = ~av; b = bv + 64'd3; sub = 1'b0;
         @(posedge clk); #1;
         check_val({name, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
         check_val({name, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
         check_val({name, "_hold_sum"}, sum, e.sum);
         check_val({name, "_hold_cout"}, {63'd0, c_out}, {63'd0, e.c_out});
         check_val({name, "_hold_ovf"}, {63'd0, overflow}, {63'd0, e.ovf});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_val({name, "_release_valid"}, {63'd0, out_valid}, 64'd0);
      check_val({name, "_release_ready"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("rst_sum", sum, 64'd0);
      check_val("rst_c_out", {63'd0, c_out}, 64'd0);
      check_val("rst_ovf", {63'd0, overflow}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("ripple", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0);
      run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
      run_op("cin_only", 64'd0, 64'd0, 1'b1, 1'b0, 0);
      run_op("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 0);
      run_op("sub_noborrow", 64'd7, 64'd5, 1'b1, 1'b1, 0);
      run_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
      run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0);
      run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 0);
      run_op("backpressure", 64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0, 10);
      run_op("after_bp", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b1, 0);

      // Abort mid-RUN: the result of this operation must never appear.
      a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF;
      c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("abort_sum", sum, 64'd0);
      check_val("abort_in_ready", {63'd0, in_ready}, 64'd1);
      check_val("abort_c_out", {63'd0, c_out}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("abort_idle_valid", {63'd0, out_valid}, 64'd0);
      run_op("post_reset", 64'd3, 64'd4, 1'b0, 1'b0, 0);

      for (int k = 0; k < 6; k++) begin
         run_op("random", {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), k % 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_add64.md
# serial_add64

Multi-precision adder front end. It accepts wide operands over a valid/ready handshake and streams them, one 16-bit chunk per cycle, through a single combinational 16-bit carry-lookahead slice. The carry is held in a register between chunks. It sits directly upstream of the 16-bit lookahead adder, reusing one adder for operands of 16·WORDS bits, and presents the registered wide result to downstream logic with its own handshake.

## Interface
- WORDS, 4, number of 16-bit chunks; operand width W = 16·WORDS; WORDS ≥ 1
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; **one clock; reset is asynchronous and active-low**
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- c_in  input  1  carry in (add mode only)
- sub  input  1  1 = compute a − b
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  W  result
- c_out  output  1  carry out of bit W−1; in sub mode, 1 = no borrow
- overflow  output  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - latch a_r = a;
    - latch b_r = sub ? ~b : b;
    - carry_r = sub ? 1 : c_in;
    - idx = 0; clear sum_r; go to RUN.
  - RUN: the slice adds a_r[idx], b_r[idx] and carry_r.
    - sum_r[idx] ← slice sum; carry_r ← slice carry out.
    - If idx == WORDS−1, go to DONE; else idx + 1.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Outputs:
  - in_ready = (state == IDLE); out_valid = (state == DONE); both are decoded from the state register only.
  - sum = sum_r; c_out = carry_r, valid in DONE.
  - overflow = (a_r[W−1] == b_r[W−1]) & (sum_r[W−1] != a_r[W−1]), registered on the final RUN cycle.
- Width rules:
  - Arithmetic is modulo 2^W. c_out is the only carry beyond W bits.
  - In sub mode c_in is ignored.
  - idx width is clog2(WORDS), minimum 1.
- Boundary conditions:
  - There is no overlap. in_valid is ignored outside IDLE, and operands present then are not consumed.
  - out_ready is ignored outside DONE.
  - While DONE with out_ready = 0, sum, c_out and overflow hold stable indefinitely.
  - DONE → IDLE takes one cycle. A new operand can be accepted no earlier than the cycle after the result handshake.
  - WORDS = 1: RUN lasts exactly one cycle.
  - Reset mid-RUN or mid-DONE aborts the operation immediately; no partial result is ever presented.
- Reset values:
  - state = IDLE.
  - sum_r, a_r, b_r, carry_r, overflow_r, idx = 0.
  - Resulting outputs: in_ready = 1, out_valid = 0, sum = 0, c_out = 0, overflow = 0.

## Timing
- Accept edge T (in_valid & in_ready sampled high).
- Chunks 0..WORDS−1 are computed on edges T+1..T+WORDS.
- out_valid is high from T+WORDS, i.e. WORDS cycles after accept (4 for the default).
- If out_ready is high in the first DONE cycle, the result handshake occurs at edge T+WORDS+1 and in_ready returns high after that edge.
- Throughput: one operation per WORDS+2 cycles maximum.
- Critical path: carry_r → 16-bit CLA slice → sum_r/carry_r. There is no path from in_valid or out_ready to any output.

## Structure
- Shared package holds:
  - CHUNK = 16;
  - state encoding typedef (IDLE/RUN/DONE);
  - function computing the idx width from WORDS.
- One sub-module, add16_slice: a combinational 16-bit carry-lookahead adder with carry in, sum and carry out, with 4-bit group carries computed directly.
  - It is instantiated once.
  - The FSM, chunk multiplexing and result registers live in serial_add64.

## Test plan
All scenarios use WORDS = 4.
- **Carry ripple:** a = 0x0000_0000_0000_FFFF, b = 1, c_in = 0 → sum = 0x0000_0000_0001_0000, c_out = 0, overflow = 0, out_valid exactly 4 cycles after accept.
- **Full wrap:** a = 0xFFFF_FFFF_FFFF_FFFF, b = 1 → sum = 0, c_out = 1, overflow = 0. Also a = b = 0 with c_in = 1 → sum = 1.
- **Subtract with borrow:** sub = 1, a = 5, b = 7 → sum = 0xFFFF_FFFF_FFFF_FFFE, c_out = 0, overflow = 0. Also sub = 1, a = 7, b = 5 → sum = 2, c_out = 1.
- **Signed overflow:** a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 → sum = 0x8000_0000_0000_0000, overflow = 1, c_out = 0.
- **Backpressure:** out_ready held low for 10 cycles in DONE.
  - Required response: sum, c_out, overflow stable; in_ready = 0; a second in_valid is not accepted.
  - After out_ready rises: one handshake, then in_ready = 1 and the second operand pair is accepted.
- **Reset mid-RUN:** assert rst_n = 0 two cycles after accept.
  - During reset: out_valid = 0, sum = 0, in_ready = 1 asynchronously.
  - After release: a fresh add (3 + 4) returns 7 with normal latency.
